// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice (package pc_pkg).
//   state_t : FSM encoding (ST_RUN, ST_TRAP)
//   sel_t   : next-PC source (SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET, SEL_ERET, SEL_VEC)
//   dbg_t   : debug view of the FSM and the stack requests for checkers
//   DEF_EXC_VECTOR : default trap entry address
package pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_RET  = 3'd3,
    SEL_ERET = 3'd4,
    SEL_VEC  = 3'd5
  } sel_t;

  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

  typedef struct packed {
    state_t state;  // current FSM state
    sel_t   sel;    // next-PC source chosen this cycle
    logic   push;   // return address pushed this cycle
    logic   pop;    // return address popped this cycle
  } dbg_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bus.
// Handshake: there is no valid/ready pair here; Signal_write acts as a
// one-sided advance strobe sampled on every rising clock edge. When it is low
// the sequencer holds (except for Exception, which is always accepted in RUN).
// Outputs are registered except Pc_plus, which is Data + PC_INC.
//   master : control unit (drives requests, reads PC)
//   slave  : pc_sequencer
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              Signal_write;
  logic              Branch_taken;
  logic [ADDR_W-1:0] Branch_target;
  logic              Jump;
  logic [ADDR_W-1:0] Jump_target;
  logic              Exception;
  logic              Eret;
  logic              Call;
  logic              Ret;
  logic [ADDR_W-1:0] Data;
  logic [ADDR_W-1:0] Pc_plus;
  logic [ADDR_W-1:0] Epc;
  logic              Trap_busy;
  logic              Misaligned;

  modport master (
    output Signal_write, Branch_taken, Branch_target, Jump, Jump_target,
           Exception, Eret, Call, Ret,
    input  Data, Pc_plus, Epc, Trap_busy, Misaligned
  );

  modport slave (
    input  Signal_write, Branch_taken, Branch_target, Jump, Jump_target,
           Exception, Eret, Call, Ret,
    output Data, Pc_plus, Epc, Trap_busy, Misaligned
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack.
// Ports: i_clk, i_rst (async, active-high), i_push/i_data (write new top),
//        i_pop (drop top), o_top (current top), o_valid (stack not empty).
// A push onto a full stack overwrites the oldest entry; the count saturates.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_valid
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;  // next slot to write
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_top_idx = (r_ptr == '0) ? PTR_W'(DEPTH - 1) : r_ptr - 1'b1;
  assign w_ptr_inc = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_valid   = (r_cnt != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (r_cnt != CNT_W'(DEPTH)) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && o_valid) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_ptr] <= i_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with next-PC selection and trap handling.
// Ports: Clock_in, Signal_reset (async, active-high), bus (pc_sequencer_if.slave),
//        o_dbg (FSM state / select / stack activity).
// Optional feature: define PC_RAS_EN to add a RAS_DEPTH-entry return-address
// stack driven by bus.Call/bus.Ret; without it Call and Ret have no effect.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                PC_INC      = 4,
  parameter int                ALIGN_BITS  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(DEF_EXC_VECTOR),
  parameter int                TRAP_CYCLES = 2,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic                  Clock_in,
  input  logic                  Signal_reset,
  pc_sequencer_if.slave         bus,
  output dbg_t                  o_dbg
);
  localparam int CNT_W = $clog2(TRAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    (ALIGN_BITS == 0) ? '0 : ((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_trap_cnt, w_next_cnt;
  logic [ADDR_W-1:0] r_data, w_next_data;
  logic [ADDR_W-1:0] r_epc, w_next_epc;
  logic              r_misaligned;

  sel_t              w_sel;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_plus;
  logic              w_adv;
  logic              w_take_trap;
  logic              w_mis;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_valid;

  assign w_pc_plus = r_data + ADDR_W'(PC_INC);

`ifdef PC_RAS_EN
  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .i_clk   (Clock_in),
    .i_rst   (Signal_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_plus),
    .o_top   (w_ras_top),
    .o_valid (w_ras_valid)
  );
`else
  assign w_ras_top   = '0;
  assign w_ras_valid = 1'b0;
`endif

  always_ff @(posedge Clock_in or posedge Signal_reset) begin
    if (Signal_reset) begin
      r_state      <= ST_RUN;
      r_trap_cnt   <= '0;
      r_data       <= RESET_PC;
      r_epc        <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_trap_cnt   <= w_next_cnt;
      r_data       <= w_next_data;
      r_epc        <= w_next_epc;
      r_misaligned <= w_mis;
    end
  end

  always_comb begin
    w_sel        = SEL_SEQ;
    w_adv        = 1'b0;
    w_take_trap  = 1'b0;
    w_mis        = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_target     = w_pc_plus;
    w_next_state = r_state;
    w_next_cnt   = r_trap_cnt;
    w_next_data  = r_data;
    w_next_epc   = r_epc;

    unique case (r_state)
      ST_RUN: begin
        if (bus.Exception) begin
          w_sel       = SEL_VEC;
          w_take_trap = 1'b1;
        end else if (bus.Signal_write) begin
          w_adv = 1'b1;
          if (bus.Eret)              w_sel = SEL_ERET;
          else if (bus.Jump)         w_sel = SEL_JMP;
          else if (RAS_EN && bus.Ret)
            // Ret on an empty stack falls back to sequential flow.
            w_sel = w_ras_valid ? SEL_RET : SEL_SEQ;
          else if (bus.Branch_taken) w_sel = SEL_BR;
          else                       w_sel = SEL_SEQ;
        end
      end
      ST_TRAP: begin
        // Everything is ignored here; a new Exception is simply dropped.
        w_sel = SEL_VEC;
        if (r_trap_cnt == '0) w_next_state = ST_RUN;
        else                  w_next_cnt   = r_trap_cnt - 1'b1;
      end
      default: w_next_state = ST_RUN;
    endcase

    unique case (w_sel)
      SEL_BR:   w_target = bus.Branch_target;
      SEL_JMP:  w_target = bus.Jump_target;
      SEL_RET:  w_target = w_ras_top;
      SEL_ERET: w_target = r_epc;
      SEL_VEC:  w_target = EXC_VECTOR;
      default:  w_target = w_pc_plus;
    endcase

    // A bad control-flow target becomes a trap instead of an update.
    if (w_adv && (w_sel == SEL_BR || w_sel == SEL_JMP || w_sel == SEL_RET) &&
        ((w_target & ALIGN_MASK) != '0)) begin
      w_mis       = 1'b1;
      w_take_trap = 1'b1;
      w_adv       = 1'b0;
    end

    w_push = w_adv && (w_sel == SEL_JMP) && bus.Call;
    w_pop  = w_adv && (w_sel == SEL_RET);

    if (w_take_trap) begin
      w_next_state = ST_TRAP;
      w_next_cnt   = CNT_W'(TRAP_CYCLES - 1);
      w_next_epc   = r_data;
      w_next_data  = EXC_VECTOR;
    end else if (w_adv) begin
      w_next_data = w_target;
    end
  end

  assign bus.Data       = r_data;
  assign bus.Pc_plus    = w_pc_plus;
  assign bus.Epc        = r_epc;
  assign bus.Trap_busy  = (r_state == ST_TRAP);
  assign bus.Misaligned = r_misaligned;

  assign o_dbg.state = r_state;
  assign o_dbg.sel   = w_sel;
  assign o_dbg.push  = w_push;
  assign o_dbg.pop   = w_pop;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk;
  logic rst;
  dbg_t dbg;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer dut (
    .Clock_in     (clk),
    .Signal_reset (rst),
    .bus          (bus),
    .o_dbg        (dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic        eret;
    logic        call;
    logic        ret;
    logic [31:0] e_data;
    logic [31:0] e_epc;
    logic        e_busy;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic br, input logic [31:0] bt,
                              input logic jmp, input logic [31:0] jt, input logic exc,
                              input logic eret, input logic call, input logic ret,
                              input logic [31:0] e_data, input logic [31:0] e_epc,
                              input logic e_busy, input logic e_mis);
    vec_t v;
    v.wr = wr; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt; v.exc = exc;
    v.eret = eret; v.call = call; v.ret = ret; v.e_data = e_data;
    v.e_epc = e_epc; v.e_busy = e_busy; v.e_mis = e_mis;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic wr, input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt, input logic exc,
                       input logic eret, input logic call, input logic ret);
    bus.Signal_write  = wr;
    bus.Branch_taken  = br;
    bus.Branch_target = bt;
    bus.Jump          = jmp;
    bus.Jump_target   = jt;
    bus.Exception     = exc;
    bus.Eret          = eret;
    bus.Call          = call;
    bus.Ret           = ret;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // one edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_data,
                           input logic [31:0] e_epc, input logic e_busy, input logic e_mis);
    check({tag, " data"}, bus.Data, e_data);
    check({tag, " pc_plus"}, bus.Pc_plus, e_data + 32'd4);
    check({tag, " epc"}, bus.Epc, e_epc);
    check({tag, " busy"}, {31'd0, bus.Trap_busy}, {31'd0, e_busy});
    check({tag, " mis"}, {31'd0, bus.Misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    logic [31:0] exp_ret;

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    //           wr   br   bt            jmp  jt            exc  eret call ret  data          epc          busy mis
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h4,        32'h0,   0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h8,        32'h0,   0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'hC,        32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 32'h400,      0, 32'h0,        0, 0, 0, 0, 32'hC,        32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 32'h100,      0, 32'h0,        0, 0, 0, 0, 32'h100,      32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 32'h200,      1, 32'h300,      0, 0, 0, 0, 32'h300,      32'h0,   0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h40,       0, 0, 0, 0, 32'h40,       32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h80,       32'h40,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h80,       32'h40,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h80,       32'h40,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h40,       32'h40,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h102,      0, 0, 0, 0, 32'h80,       32'h40,  1, 1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h40,  1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h40,  0, 0));
    vecs.push_back(mk(1, 1, 32'h201,      0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h80,  1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h80,  1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h80,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 0, 0, 0, 32'hFFFF_FFFC,32'h80,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h80,  0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h80,       32'h0,   1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h0,   1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h80,       32'h0,   0, 0));
`ifdef PC_RAS_EN
    // Ret with an empty stack: sequential flow, branch not taken
    vecs.push_back(mk(1, 1, 32'h300,      0, 32'h0,        0, 0, 0, 1, 32'h84,       32'h0,   0, 0));
`else
    // Ret has no effect: the branch below it is taken
    vecs.push_back(mk(1, 1, 32'h300,      0, 32'h0,        0, 0, 0, 1, 32'h300,      32'h0,   0, 0));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt,
            vecs[i].exc, vecs[i].eret, vecs[i].call, vecs[i].ret);
      step();
      check_all($sformatf("row%0d", i), vecs[i].e_data, vecs[i].e_epc,
                vecs[i].e_busy, vecs[i].e_mis);
    end

    // Async reset in the middle of a trap
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
    step();
    check("midtrap busy", {31'd0, bus.Trap_busy}, 32'd1);
    idle();
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // Three sequential advances after reset
    exp_q = '{32'h4, 32'h8, 32'hC};
    drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_all($sformatf("seq%0d", k), exp_q.pop_front(), 32'h0, 1'b0, 1'b0);
    end

`ifdef PC_RAS_EN
    // Call/return through the stack
    drive(1, 0, 32'h0, 1, 32'h10, 0, 0, 0, 0);
    step();
    check("ras goto", bus.Data, 32'h10);
    drive(1, 0, 32'h0, 1, 32'h500, 0, 0, 1, 0);
    step();
    check("ras call", bus.Data, 32'h500);
    drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    step();
    check("ras ret", bus.Data, 32'h14);

    // Five nested calls into a four-deep stack; the oldest return is lost
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_front(bus.Data + 32'd4);
      drive(1, 0, 32'h0, 1, 32'h1000 * k, 0, 0, 1, 0);
      step();
      check($sformatf("nest call%0d", k), bus.Data, 32'h1000 * k);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
      step();
      exp_ret = exp_q.pop_front();
      check($sformatf("nest ret%0d", k), bus.Data, exp_ret);
    end
    drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    step();
    check("nest ret5 empty", bus.Data, exp_ret + 32'd4);
    check("nest ret5 mis", {31'd0, bus.Misaligned}, 32'd0);
`else
    // Ret and Call alone leave sequential flow unchanged
    drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1);
    step();
    check("noras ret", bus.Data, 32'h10);
`endif

    idle();
    step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
